// File: rtl/key_cmd_encoder.sv
// key_cmd_encoder: debounced push-button front end issuing start/pause/clear pulses.
module key_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_n_i,
  input  logic       finish_i,
  output logic       start_o,
  output logic       pause_o,
  output logic       clear_o,
  output logic [1:0] state_o,
  output logic [2:0] key_level_o
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [2:0] r_sync1, r_sync2, r_stable, r_stable_d, r_armed, r_press;
  logic [1:0] r_warm;
  logic [CNT_W-1:0] r_cnt [3];
  state_t r_state, w_next;
  logic r_start, r_pause, r_clear, w_start, w_pause, w_clear;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_warm <= '0;
    end else begin
      r_sync1 <= key_n_i;
      r_sync2 <= r_sync1;
      r_warm <= {r_warm[0], 1'b1};
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        r_cnt[i] <= '0;
        r_stable[i] <= 1'b1;
      end else if (r_sync2[i] == r_stable[i]) r_cnt[i] <= '0;
      else if (r_cnt[i] == LIMIT) begin
        r_cnt[i] <= '0;
        r_stable[i] <= r_sync2[i];
      end else r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end
  // A key is armed only once it has been seen released, so a key held through reset never fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable_d <= '1;
      r_armed <= '0;
      r_press <= '0;
    end else begin
      r_stable_d <= r_stable;
      r_armed <= r_armed | (r_warm[1] ? (r_sync2 & r_stable) : 3'b000);
      r_press <= r_stable_d & ~r_stable & r_armed;
    end
  end
  always_comb begin
    w_next = r_state;
    w_start = 1'b0;
    w_pause = 1'b0;
    w_clear = 1'b0;
    if (r_press[2]) begin
      w_next = IDLE;
      w_clear = 1'b1;
    end else if (r_state == IDLE && r_press[0]) begin
      w_next = RUN;
      w_start = 1'b1;
    end else if (r_state == RUN && finish_i) w_next = DONE;
    else if ((r_state == RUN || r_state == PAUSED) && r_press[1]) begin
      w_next = (r_state == RUN) ? PAUSED : RUN;
      w_pause = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_pause <= 1'b0;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= w_start;
      r_pause <= w_pause;
      r_clear <= w_clear;
    end
  end
  assign start_o = r_start;
  assign pause_o = r_pause;
  assign clear_o = r_clear;
  assign state_o = r_state;
  assign key_level_o = ~r_stable;
endmodule

// File: tb/tb_key_cmd_encoder.sv
// tb_key_cmd_encoder: directed stimulus with a queue scoreboard for the command pulses.
module tb_key_cmd_encoder;
  localparam int N = 4;
  localparam int LAT = N + 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] key_n_i = 3'b111;
  logic finish_i = 1'b0;
  logic start_o, pause_o, clear_o;
  logic [1:0] state_o;
  logic [2:0] key_level_o;
  typedef struct {int cyc; logic [2:0] cmd; logic [1:0] st;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  key_cmd_encoder #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .key_n_i(key_n_i), .finish_i(finish_i),
    .start_o(start_o), .pause_o(pause_o), .clear_o(clear_o),
    .state_o(state_o), .key_level_o(key_level_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at cyc %0d", name, got, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic expect_cmd(input logic [2:0] cmd, input logic [1:0] st);
    exp_t e;
    e.cyc = cyc + LAT;
    e.cmd = cmd;
    e.st = st;
    q.push_back(e);
  endtask
  task automatic press(input logic [2:0] keys, input logic [2:0] cmd, input logic [1:0] st, input bit expect_it);
    if (expect_it) expect_cmd(cmd, st);
    key_n_i = ~keys;
    tick(12);
    key_n_i = 3'b111;
    tick(12);
  endtask
  always @(negedge clk) begin
    if (start_o | pause_o | clear_o) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd got={clear,pause,start}=%b state=%0d exp=none at cyc %0d",
                 {clear_o, pause_o, start_o}, state_o, cyc);
      end else begin
        e_m = q.pop_front();
        check("cmd", int'({clear_o, pause_o, start_o}), int'(e_m.cmd));
        check("cmd_state", int'(state_o), int'(e_m.st));
        check("cmd_cycle", cyc, e_m.cyc);
      end
    end
  end
  initial begin
    tick(3);
    rst = 1'b0;
    tick(5);
    check("reset_state", int'(state_o), 0);
    check("reset_cmds", int'({clear_o, pause_o, start_o}), 0);
    check("reset_level", int'(key_level_o), 0);
    // 1: held start key gives one pulse only
    expect_cmd(3'b001, 2'd1);
    key_n_i = 3'b110;
    tick(20);
    check("level_held", int'(key_level_o), 1);
    key_n_i = 3'b111;
    tick(15);
    check("t1_state", int'(state_o), 1);
    // 2: short glitch ignored, clean presses toggle pause
    key_n_i = 3'b101;
    tick(3);
    key_n_i = 3'b111;
    tick(12);
    check("t2_glitch_state", int'(state_o), 1);
    press(3'b010, 3'b010, 2'd2, 1'b1);
    press(3'b010, 3'b010, 2'd1, 1'b1);
    // 3: finish wins over a coinciding pause press
    key_n_i = 3'b101;
    tick(LAT - 1);
    finish_i = 1'b1;
    tick(1);
    finish_i = 1'b0;
    check("t3_done", int'(state_o), 3);
    key_n_i = 3'b111;
    tick(12);
    press(3'b001, 3'b000, 2'd3, 1'b0);
    press(3'b010, 3'b000, 2'd3, 1'b0);
    check("t3_done_hold", int'(state_o), 3);
    press(3'b100, 3'b100, 2'd0, 1'b1);
    // 4: start beats pause in IDLE; clear beats pause in PAUSED
    press(3'b011, 3'b001, 2'd1, 1'b1);
    press(3'b010, 3'b010, 2'd2, 1'b1);
    press(3'b110, 3'b100, 2'd0, 1'b1);
    // 5: reset mid-debounce with the key still held
    key_n_i = 3'b110;
    tick(4);
    rst = 1'b1;
    tick(2);
    check("t5_rst_cmds", int'({clear_o, pause_o, start_o}), 0);
    check("t5_rst_state", int'(state_o), 0);
    check("t5_rst_level", int'(key_level_o), 0);
    rst = 1'b0;
    tick(20);
    check("t5_no_start", int'(state_o), 0);
    check("t5_level", int'(key_level_o), 1);
    key_n_i = 3'b111;
    tick(15);
    press(3'b001, 3'b001, 2'd1, 1'b1);
    // 6: bouncing start key, timed from the last falling edge
    press(3'b100, 3'b100, 2'd0, 1'b1);
    key_n_i = 3'b110;
    tick(2);
    key_n_i = 3'b111;
    tick(1);
    key_n_i = 3'b110;
    expect_cmd(3'b001, 2'd1);
    tick(20);
    key_n_i = 3'b111;
    tick(15);
    check("t6_state", int'(state_o), 1);
    check("pending_cmds", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_cmd_encoder.md
Name: key_cmd_encoder

Overview:
- Input-side counterpart of the seven-segment status decoder.
- Takes raw DE2 push-buttons (active-low), synchronises and debounces them, and detects presses.
- Issues single-cycle start / pause / clear command pulses, gated by an IDLE/RUN/PAUSED/DONE FSM whose encoding matches the display side.
- Illegal presses never reach the core or the display.

Parameters:
DEBOUNCE_CYCLES  500000  cycles a synchronised key level must stay changed before it is accepted (10 ms at 50 MHz); legal range 2..2^CNT_W-1
CNT_W  20  debounce counter width

Ports:
clk  input  1  system clock, single domain
rst  input  1  synchronous, active-high reset
key_n_i  input  3  raw buttons, active-low, asynchronous; [0]=start, [1]=pause (toggle), [2]=clear
finish_i  input  1  level or pulse from core: processing complete
start_o  output  1  one-cycle start command
pause_o  output  1  one-cycle pause-toggle command
clear_o  output  1  one-cycle clear/abort command
state_o  output  2  0=IDLE, 1=RUN, 2=PAUSED, 3=DONE
key_level_o  output  3  debounced key levels, active-high (1 = held), for LEDs

Behaviour:
- Reset (rst high at a clk edge):
  - synchroniser flops and stable levels = 1 (released); counters = 0; press flags = 0.
  - start_o/pause_o/clear_o = 0, state_o = IDLE, key_level_o = 0.
  - Reset mid-debounce discards the partial count; no pulse is produced after reset release for a key that was already held.
- Synchroniser: 2-flop per key.
- Debounce, per key:
  - if sync2 == stable, counter <= 0.
  - else counter increments; when counter == DEBOUNCE_CYCLES-1 and sync2 still differs, stable <= sync2 and counter <= 0.
  - A bounce back to the stable level restarts the count from 0.
- Press detect: registered flag high for exactly one cycle when stable goes 1->0. Release produces nothing. A held key yields one press only.
- Latency: press flag high at rising edge DEBOUNCE_CYCLES+3 after the first edge that samples key low (2 sync + DEBOUNCE_CYCLES + 1).
- FSM (registered; command outputs registered, asserted in the cycle after the press flag):
  - Any state, clear press: -> IDLE, clear_o=1. Highest priority; other same-cycle events dropped.
  - IDLE, start press: -> RUN, start_o=1. Pause press ignored. finish_i ignored.
  - RUN, finish_i=1: -> DONE. A same-cycle pause press is dropped; no pause_o.
  - RUN, pause press (finish_i=0): -> PAUSED, pause_o=1.
  - PAUSED, pause press: -> RUN, pause_o=1. finish_i ignored (core stalled).
  - DONE: start and pause presses ignored; only clear leaves DONE.
- Simultaneous start+pause press in IDLE: start wins, pause dropped.
- Dropped presses are never queued or replayed.
- At most one of start_o/pause_o/clear_o is high in any cycle.
- state_o reflects the registered state; it updates in the same cycle the command pulse is asserted.
- key_level_o = ~stable.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then key_n_i[0] low and held -> start_o high exactly 1 cycle, 8 edges after first low sample; state_o 0->1; no further pulses while held or on release.
2. key_n_i[1] glitch low for 3 cycles in RUN -> no pause_o, state_o stays 1. Clean press -> pause_o pulse, state_o=2. Second press -> pause_o, state_o=1.
3. RUN, pause press flag coincides with finish_i=1 -> state_o=3, pause_o stays 0. Subsequent start/pause presses -> no outputs. Clear press -> clear_o pulse, state_o=0.
4. IDLE, start and pause pressed on the same cycle -> start_o only, state_o=1. Clear and pause pressed together in PAUSED -> clear_o only, state_o=0.
5. rst asserted at count 2 of a start debounce, key kept low -> all outputs 0, state_o=0, no start_o after release of rst. Release and re-press -> normal start_o.
6. Bouncing key (low 2, high 1, low held) -> single start_o, timed from the last high->low transition.
